alu: RTL and testbench

Combinational integer ALU for the piRISC datapath, executing the RV32I R-type arithmetic/logic operations selected by a 5-bit opcode. The result is available in the same cycle the operands and opcode are applied. A small clocked status register captures condition flags of the current result every cycle for use by branch/debug logic.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_addsub.sv | 24 ++
 rtl/alu.sv | 81 ++++++++
 tb/tb_alu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and status-flag layout for the piRISC integer ALU.
// Opcode = {alt, funct3[2:0], rtype}; SLTU/SRL/SRA decode only with ALU_SHIFT_EXT_EN.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b10001;
  localparam logic [4:0] OP_SLL  = 5'b00011;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLTU = 5'b00111;
  localparam logic [4:0] OP_XOR  = 5'b01001;
  localparam logic [4:0] OP_SRL  = 5'b01011;
  localparam logic [4:0] OP_SRA  = 5'b11011;
  localparam logic [4:0] OP_OR   = 5'b01101;
  localparam logic [4:0] OP_AND  = 5'b01111;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor (a + b, or a + ~b + 1) with carry-out and signed overflow.
// The subtract path doubles as the signed/unsigned comparator for SLT/SLTU.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  assign b_eff   = sub_i ? ~b_i : b_i;
  assign total   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
  assign sum_o   = total[WIDTH-1:0];
  assign carry_o = total[WIDTH];
  // Overflow when effective operand signs match but the result sign flips.
  assign ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Combinational RV32I R-type ALU with a registered {ovf, carry, neg, zero} status register.
// Define ALU_SHIFT_EXT_EN to add SLTU, SRL and SRA.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 5
) (
  output logic [WIDTH-1:0]    out,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                clk,
  input  logic                rst,
  output logic [3:0]          flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic             add_carry;
  logic             add_ovf;
  logic             sub_sel;
  logic             lt_s;
  logic [SHW-1:0]   shamt;
  alu_flags_t       flags_d;
  alu_flags_t       flags_q;

  // Everything except ADD runs the adder in subtract mode (SUB, SLT, SLTU compare).
  assign sub_sel = (opcode != OP_ADD);
  assign shamt   = b[SHW-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i     (a),
    .b_i     (b),
    .sub_i   (sub_sel),
    .sum_o   (sum),
    .carry_o (add_carry),
    .ovf_o   (add_ovf)
  );

  assign lt_s = sum[WIDTH-1] ^ add_ovf;

  always_comb begin
    out = '0;
    case (opcode)
      OP_ADD:  out = sum;
      OP_SUB:  out = sum;
      OP_SLL:  out = a << shamt;
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, lt_s};
      OP_XOR:  out = a ^ b;
      OP_OR:   out = a | b;
      OP_AND:  out = a & b;
`ifdef ALU_SHIFT_EXT_EN
      // a - b borrows exactly when a < b unsigned.
      OP_SLTU: out = {{(WIDTH-1){1'b0}}, ~add_carry};
      OP_SRL:  out = a >> shamt;
      OP_SRA:  out = $signed(a) >>> shamt;
`endif
      default: out = '0;
    endcase
  end

  always_comb begin
    flags_d       = '0;
    flags_d.zero  = (out == '0);
    flags_d.neg   = out[WIDTH-1];
    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
      flags_d.carry = add_carry;
      flags_d.ovf   = add_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed and random-vector self-checking bench for the alu block.
module tb_alu;

  logic [31:0] out;
  logic [4:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        clk;
  logic        rst;
  logic [3:0]  flags;

  int n_cmp;
  int n_fail;

  alu #(.WIDTH(32), .OP_WIDTH(5)) dut (
    .out    (out),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .clk    (clk),
    .rst    (rst),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: plain arithmetic, not an adder structure.
  function automatic logic [31:0] model_out(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      5'b00001: return x + y;
      5'b10001: return x - y;
      5'b00011: return x << y[4:0];
      5'b00101: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'b01001: return x ^ y;
      5'b01101: return x | y;
      5'b01111: return x & y;
`ifdef ALU_SHIFT_EXT_EN
      5'b00111: return (x < y) ? 32'd1 : 32'd0;
      5'b01011: return x >> y[4:0];
      5'b11011: return $signed(x) >>> y[4:0];
`endif
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] model_flags(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic [32:0] wide;
    longint      s;
    logic        c;
    logic        v;
    r = model_out(op, x, y);
    c = 1'b0;
    v = 1'b0;
    if (op == 5'b00001) begin
      wide = {1'b0, x} + {1'b0, y};
      c = wide[32];
      s = longint'($signed(x)) + longint'($signed(y));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op == 5'b10001) begin
      c = (x >= y);
      s = longint'($signed(x)) - longint'($signed(y));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {v, c, r[31], (r == 32'd0)};
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    opcode = op;
    a = x;
    b = y;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(5'b00001, 32'd2, 32'd3);
    n_cmp++;
    if (out !== 32'd5) begin
      n_fail++;
      $display("FAIL reset_out_passthru: got %h expected %h", out, 32'd5);
    end
    tick();
    n_cmp++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected %b", flags, 4'b0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    drive(5'b00001, 32'hFFFF_FFFF, 32'h0000_0001);
    n_cmp++;
    if (out !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL add_wrap_out: got %h expected %h", out, 32'h0);
    end
    tick();
    n_cmp++;
    if (flags !== 4'b0101) begin
      n_fail++;
      $display("FAIL add_wrap_flags: got %b expected %b", flags, 4'b0101);
    end
    drive(5'b10001, 32'h8000_0000, 32'h0000_0001);
    n_cmp++;
    if (out !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL sub_ovf_out: got %h expected %h", out, 32'h7FFF_FFFF);
    end
    tick();
    n_cmp++;
    if (flags !== 4'b1100) begin
      n_fail++;
      $display("FAIL sub_ovf_flags: got %b expected %b", flags, 4'b1100);
    end
    drive(5'b10001, 32'h0000_0001, 32'h0000_0002);
    n_cmp++;
    if (out !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sub_borrow_out: got %h expected %h", out, 32'hFFFF_FFFF);
    end
    tick();
    n_cmp++;
    if (flags !== 4'b0010) begin
      n_fail++;
      $display("FAIL sub_borrow_flags: got %b expected %b", flags, 4'b0010);
    end
  endtask

  task automatic test_slt();
    logic [31:0] va [3] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'h1234_5678};
    logic [31:0] vb [3] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h1234_5678};
    logic [31:0] ve [3] = '{32'd1, 32'd0, 32'd0};
    for (int i = 0; i < 3; i++) begin
      drive(5'b00101, va[i], vb[i]);
      n_cmp++;
      if (out !== ve[i]) begin
        n_fail++;
        $display("FAIL slt_%0d: got %h expected %h", i, out, ve[i]);
      end
    end
    tick();
    n_cmp++;
    if (flags !== 4'b0001) begin
      n_fail++;
      $display("FAIL slt_flags: got %b expected %b", flags, 4'b0001);
    end
  endtask

  task automatic test_logic_shift();
    logic [4:0]  ops [4] = '{5'b00011, 5'b01001, 5'b01101, 5'b01111};
    logic [31:0] va  [4] = '{32'h0000_0001, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF};
    logic [31:0] vb  [4] = '{32'h0000_0023, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F};
    logic [31:0] ve  [4] = '{32'h0000_0008, 32'hFF00_0FF0, 32'hFFF0_0FFF, 32'h00F0_000F};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], va[i], vb[i]);
      n_cmp++;
      if (out !== ve[i]) begin
        n_fail++;
        $display("FAIL logic_shift_%0d: got %h expected %h", i, out, ve[i]);
      end
    end
    tick();
    n_cmp++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL and_flags: got %b expected %b", flags, 4'b0000);
    end
  endtask

  task automatic test_undefined();
    logic [4:0] ops [4] = '{5'b00000, 5'b01011, 5'b00010, 5'b11111};
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 4; i++) begin
      x = $urandom | 32'h8000_0001;
      y = $urandom;
      drive(ops[i], x, y);
      n_cmp++;
      if (out !== model_out(ops[i], x, y)) begin
        n_fail++;
        $display("FAIL undef_op_%b: got %h expected %h", ops[i], out, model_out(ops[i], x, y));
      end
      tick();
      n_cmp++;
      if (flags !== model_flags(ops[i], x, y)) begin
        n_fail++;
        $display("FAIL undef_flags_%b: got %b expected %b", ops[i], flags, model_flags(ops[i], x, y));
      end
    end
  endtask

  task automatic test_rst_midstream();
    drive(5'b00001, 32'hFFFF_FFFF, 32'h0000_0002);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_clear: got %b expected %b", flags, 4'b0000);
    end
    n_cmp++;
    if (out !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL midrst_out: got %h expected %h", out, 32'h1);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++;
    if (flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_resume: got %b expected %b", flags, 4'b0100);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops [7] = '{5'b00001, 5'b10001, 5'b00011, 5'b00101, 5'b01001, 5'b01101, 5'b01111};
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  ef;
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 10; i++) begin
        x = $urandom;
        y = $urandom;
        if (i == 0) y = x;
        if (i == 1) y = ~x;
        drive(ops[k], x, y);
        n_cmp++;
        if (out !== model_out(ops[k], x, y)) begin
          n_fail++;
          $display("FAIL rand_out op=%b a=%h b=%h: got %h expected %h", ops[k], x, y, out, model_out(ops[k], x, y));
        end
        ef = model_flags(ops[k], x, y);
        tick();
        n_cmp++;
        if (flags !== ef) begin
          n_fail++;
          $display("FAIL rand_flags op=%b a=%h b=%h: got %b expected %b", ops[k], x, y, flags, ef);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    opcode = 5'b0;
    a      = 32'd0;
    b      = 32'd0;
    test_reset();
    test_add_sub();
    test_slt();
    test_logic_shift();
    test_undefined();
    test_rst_midstream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
